// File: rtl/multi_bank_fifo_pkg.sv
// Shared constants, master naming and sizing helper for the banked dual-master FIFO.
package multi_bank_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_BANK_NUM   = 4;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  // Bank-id port width; a single-bit id is kept even for degenerate bank counts.
  function automatic int bank_id_width(input int bank_num);
    return (bank_num > 1) ? $clog2(bank_num) : 1;
  endfunction

endpackage

// File: rtl/multi_bank_fifo_fifo_bank.sv
// One circular FIFO bank: registered full/empty, combinational head on dout.
module fifo_bank
  import multi_bank_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/multi_bank_fifo.sv
// Dual-master banked FIFO: per-bank round-robin arbitration, grant logic and read muxing.
module multi_bank_fifo
  import multi_bank_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int BANK_NUM   = DEF_BANK_NUM,
  localparam int IDW        = bank_id_width(BANK_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_m0,
  input  logic [IDW-1:0]        wr_id_m0,
  input  logic [DATA_WIDTH-1:0] data_in_m0,
  output logic                  wr_ack_m0,
  input  logic                  wr_en_m1,
  input  logic [IDW-1:0]        wr_id_m1,
  input  logic [DATA_WIDTH-1:0] data_in_m1,
  output logic                  wr_ack_m1,
  input  logic                  rd_en_m0,
  input  logic [IDW-1:0]        rd_id_m0,
  output logic [DATA_WIDTH-1:0] data_out_m0,
  output logic                  valid_m0,
  input  logic                  rd_en_m1,
  input  logic [IDW-1:0]        rd_id_m1,
  output logic [DATA_WIDTH-1:0] data_out_m1,
  output logic                  valid_m1,
  output logic [BANK_NUM-1:0]   full,
  output logic [BANK_NUM-1:0]   empty
);

  // Handshake: wr_en/rd_en are levels. wr_ack high means the write is taken at
  // this edge; otherwise the master holds and retries. valid pulses for one
  // cycle per granted read, with data_out holding its value in between.

  logic [BANK_NUM-1:0]   wr_req0, wr_req1, rd_req0, rd_req1;
  logic [BANK_NUM-1:0]   wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic [BANK_NUM-1:0]   push, pop;
  logic [DATA_WIDTH-1:0] din  [BANK_NUM];
  logic [DATA_WIDTH-1:0] dout [BANK_NUM];
  master_e               wr_prio [BANK_NUM];
  master_e               rd_prio [BANK_NUM];

  always_comb begin
    wr_req0 = '0; wr_req1 = '0; rd_req0 = '0; rd_req1 = '0;
    wr_gnt0 = '0; wr_gnt1 = '0; rd_gnt0 = '0; rd_gnt1 = '0;
    push    = '0; pop     = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      din[b]     = '0;
      wr_req0[b] = wr_en_m0 && (wr_id_m0 == IDW'(b));
      wr_req1[b] = wr_en_m1 && (wr_id_m1 == IDW'(b));
      rd_req0[b] = rd_en_m0 && (rd_id_m0 == IDW'(b));
      rd_req1[b] = rd_en_m1 && (rd_id_m1 == IDW'(b));
      rd_gnt0[b] = rd_req0[b] && !empty[b] && (!rd_req1[b] || rd_prio[b] == M0);
      rd_gnt1[b] = rd_req1[b] && !empty[b] && (!rd_req0[b] || rd_prio[b] == M1);
      pop[b]     = rd_gnt0[b] | rd_gnt1[b];
      // A full bank still accepts a write when it is popped in the same cycle.
      wr_gnt0[b] = wr_req0[b] && (!full[b] || pop[b]) && (!wr_req1[b] || wr_prio[b] == M0);
      wr_gnt1[b] = wr_req1[b] && (!full[b] || pop[b]) && (!wr_req0[b] || wr_prio[b] == M1);
      push[b]    = wr_gnt0[b] | wr_gnt1[b];
      din[b]     = wr_gnt1[b] ? data_in_m1 : data_in_m0;
    end
  end

  assign wr_ack_m0 = |wr_gnt0;
  assign wr_ack_m1 = |wr_gnt1;

  for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
    fifo_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .din   (din[g]),
      .pop   (pop[g]),
      .dout  (dout[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m0    <= 1'b0;
      valid_m1    <= 1'b0;
      data_out_m0 <= '0;
      data_out_m1 <= '0;
      for (int b = 0; b < BANK_NUM; b++) begin
        wr_prio[b] <= M0;
        rd_prio[b] <= M0;
      end
    end else begin
      valid_m0 <= |rd_gnt0;
      valid_m1 <= |rd_gnt1;
      if (|rd_gnt0) data_out_m0 <= dout[rd_id_m0];
      if (|rd_gnt1) data_out_m1 <= dout[rd_id_m1];
      // Priority only rotates when a contested request was actually served.
      for (int b = 0; b < BANK_NUM; b++) begin
        if (wr_req0[b] && wr_req1[b] && push[b])
          wr_prio[b] <= (wr_prio[b] == M0) ? M1 : M0;
        if (rd_req0[b] && rd_req1[b] && pop[b])
          rd_prio[b] <= (rd_prio[b] == M0) ? M1 : M0;
      end
    end
  end

endmodule
